// File: rtl/ack_bus_arbiter_if.sv
// Ack bus between the requesters, the arbiter and the destination.
// The arbiter connects through master; the environment connects through slave.
interface ack_bus_arbiter_if;
    logic [3:0] MODULE_SIDE_ACK_VALID;
    logic [3:0] ACK_READY_TO_MODULE;
    logic       ACK_VALID;
    logic [1:0] MODULE_SOURCE_ID;
    logic       ACK_READY;
    logic       ERR_CLR;
    logic       TIMEOUT_ERR;
    logic [1:0] TIMEOUT_ID;
    logic       BUSY;

    modport master (
        input  MODULE_SIDE_ACK_VALID,
        input  ACK_READY,
        input  ERR_CLR,
        output ACK_READY_TO_MODULE,
        output ACK_VALID,
        output MODULE_SOURCE_ID,
        output TIMEOUT_ERR,
        output TIMEOUT_ID,
        output BUSY
    );

    modport slave (
        output MODULE_SIDE_ACK_VALID,
        output ACK_READY,
        output ERR_CLR,
        input  ACK_READY_TO_MODULE,
        input  ACK_VALID,
        input  MODULE_SOURCE_ID,
        input  TIMEOUT_ERR,
        input  TIMEOUT_ID,
        input  BUSY
    );
endinterface

// File: rtl/ack_bus_arbiter.sv
// Round-robin arbiter granting one of four requesters onto a single ack bus,
// with back-to-back re-grant on handshake and a sticky timeout abort.
module ack_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    ack_bus_arbiter_if.master  bus
);

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              ack_valid_q, ack_valid_d;
    logic              busy_q, busy_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ID_W-1:0]   tid_q, tid_d;

    logic              handshake_c;
    logic [N_REQ-1:0]  grant_oh_c;
    logic [ID_W:0]     pick_idle_c;
    logic [ID_W:0]     pick_next_c;

    // Returns {found, id}: first set request searching upward from last+1, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  last);
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = ID_W'(32'(last) + i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        grant_oh_c          = N_REQ'(1) << id_q;
        handshake_c         = ack_valid_q & bus.ACK_READY;
        pick_idle_c         = rr_pick(bus.MODULE_SIDE_ACK_VALID, last_q);
        // The finishing grantee is masked so a held request cannot win twice in a row.
        pick_next_c         = rr_pick(bus.MODULE_SIDE_ACK_VALID & ~grant_oh_c, id_q);
    end

    always_comb begin
        state_d     = state_q;
        ack_valid_d = ack_valid_q;
        busy_d      = busy_q;
        id_d        = id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        tid_d       = tid_q;

        if (bus.ERR_CLR) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_idle_c[ID_W]) begin
                    state_d = ST_GRANT;
                    id_d    = pick_idle_c[ID_W-1:0];
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (handshake_c) begin
                    last_d = id_q;
                    cnt_d  = '0;
                    if (pick_next_c[ID_W]) begin
                        id_d = pick_next_c[ID_W-1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: placed after the clear so a coincident ERR_CLR loses.
                    state_d = ST_IDLE;
                    last_d  = id_q;
                    err_d   = 1'b1;
                    tid_d   = id_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_valid_d = (state_d == ST_GRANT);
        busy_d      = (state_d == ST_GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ack_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            id_q        <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            cnt_q       <= '0;
            err_q       <= 1'b0;
            tid_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_valid_q <= ack_valid_d;
            busy_q      <= busy_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            tid_q       <= tid_d;
        end
    end

    assign bus.ACK_READY_TO_MODULE = handshake_c ? grant_oh_c : '0;
    assign bus.ACK_VALID           = ack_valid_q;
    assign bus.MODULE_SOURCE_ID    = id_q;
    assign bus.BUSY                = busy_q;
    assign bus.TIMEOUT_ERR         = err_q;
    assign bus.TIMEOUT_ID          = tid_q;

endmodule

// File: tb/tb_ack_bus_arbiter.sv
// Directed bench: dut_a uses the default timeout, dut_t uses TIMEOUT_CYCLES=4.
module tb_ack_bus_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ack_bus_arbiter_if ifa ();
    ack_bus_arbiter_if ift ();

    ack_bus_arbiter dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    ack_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (ift.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        ifa.MODULE_SIDE_ACK_VALID = 4'b0000;
        ifa.ACK_READY = 1'b0;
        ifa.ERR_CLR   = 1'b0;
        ift.MODULE_SIDE_ACK_VALID = 4'b0000;
        ift.ACK_READY = 1'b0;
        ift.ERR_CLR   = 1'b0;
        tick();
        tick();
        chk("rst_valid", 8'(ifa.ACK_VALID), 8'h0);
        chk("rst_id",    8'(ifa.MODULE_SOURCE_ID), 8'h0);
        chk("rst_busy",  8'(ifa.BUSY), 8'h0);
        chk("rst_err",   8'(ifa.TIMEOUT_ERR), 8'h0);
        chk("rst_tid",   8'(ifa.TIMEOUT_ID), 8'h0);
        chk("rst_strb",  8'(ifa.ACK_READY_TO_MODULE), 8'h0);
        rst = 1'b0;
        #1;

        // Single request; READY while idle must not strobe
        ifa.MODULE_SIDE_ACK_VALID = 4'b0001;
        ifa.ACK_READY = 1'b1;
        #1;
        chk("single_idle_strb", 8'(ifa.ACK_READY_TO_MODULE), 8'h0);
        chk("single_idle_valid", 8'(ifa.ACK_VALID), 8'h0);
        tick();
        chk("single_valid", 8'(ifa.ACK_VALID), 8'h1);
        chk("single_id",    8'(ifa.MODULE_SOURCE_ID), 8'h0);
        chk("single_busy",  8'(ifa.BUSY), 8'h1);
        chk("single_strb",  8'(ifa.ACK_READY_TO_MODULE), 8'h1);
        ifa.MODULE_SIDE_ACK_VALID = 4'b0000;
        tick();
        chk("single_done_valid", 8'(ifa.ACK_VALID), 8'h0);
        chk("single_done_busy",  8'(ifa.BUSY), 8'h0);
        chk("single_done_strb",  8'(ifa.ACK_READY_TO_MODULE), 8'h0);
        ifa.ACK_READY = 1'b0;

        // Round robin, back-to-back from a fresh reset
        do_reset();
        ifa.MODULE_SIDE_ACK_VALID = 4'b1111;
        ifa.ACK_READY = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("rr_valid", 8'(ifa.ACK_VALID), 8'h1);
            chk("rr_id",    8'(ifa.MODULE_SOURCE_ID), 8'(k % 4));
            chk("rr_strb",  8'(ifa.ACK_READY_TO_MODULE), 8'(4'b0001 << (k % 4)));
            if (k == 4) ifa.MODULE_SIDE_ACK_VALID = 4'b0000;
            tick();
        end
        chk("rr_end_valid", 8'(ifa.ACK_VALID), 8'h0);
        ifa.ACK_READY = 1'b0;

        // Backpressure; requester drops mid-grant without aborting it
        ifa.MODULE_SIDE_ACK_VALID = 4'b0100;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 8'(ifa.ACK_VALID), 8'h1);
            chk("bp_id",    8'(ifa.MODULE_SOURCE_ID), 8'h2);
            chk("bp_strb",  8'(ifa.ACK_READY_TO_MODULE), 8'h0);
            if (k == 2) ifa.MODULE_SIDE_ACK_VALID = 4'b0000;
            tick();
        end
        chk("bp_hold_id", 8'(ifa.MODULE_SOURCE_ID), 8'h2);
        ifa.ACK_READY = 1'b1;
        #1;
        chk("bp_strb_hs", 8'(ifa.ACK_READY_TO_MODULE), 8'h4);
        tick();
        chk("bp_done_valid", 8'(ifa.ACK_VALID), 8'h0);
        chk("bp_done_strb",  8'(ifa.ACK_READY_TO_MODULE), 8'h0);
        chk("bp_no_err",     8'(ifa.TIMEOUT_ERR), 8'h0);
        ifa.ACK_READY = 1'b0;

        // Timeout with TIMEOUT_CYCLES=4
        ift.MODULE_SIDE_ACK_VALID = 4'b0010;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("to_valid", 8'(ift.ACK_VALID), 8'h1);
            chk("to_id",    8'(ift.MODULE_SOURCE_ID), 8'h1);
            chk("to_strb",  8'(ift.ACK_READY_TO_MODULE), 8'h0);
            chk("to_err_lo", 8'(ift.TIMEOUT_ERR), 8'h0);
            if (k == 3) ift.MODULE_SIDE_ACK_VALID = 4'b0000;
            tick();
        end
        chk("to_valid_drop", 8'(ift.ACK_VALID), 8'h0);
        chk("to_busy_drop",  8'(ift.BUSY), 8'h0);
        chk("to_err",        8'(ift.TIMEOUT_ERR), 8'h1);
        chk("to_tid",        8'(ift.TIMEOUT_ID), 8'h1);
        chk("to_strb_after", 8'(ift.ACK_READY_TO_MODULE), 8'h0);
        ift.ERR_CLR = 1'b1;
        tick();
        ift.ERR_CLR = 1'b0;
        chk("to_clr_err", 8'(ift.TIMEOUT_ERR), 8'h0);
        chk("to_clr_tid", 8'(ift.TIMEOUT_ID), 8'h1);

        // READY in the final timeout cycle wins
        ift.MODULE_SIDE_ACK_VALID = 4'b0001;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("col_id", 8'(ift.MODULE_SOURCE_ID), 8'h0);
            tick();
        end
        chk("col_valid_last", 8'(ift.ACK_VALID), 8'h1);
        ift.MODULE_SIDE_ACK_VALID = 4'b0000;
        ift.ACK_READY = 1'b1;
        #1;
        chk("col_strb", 8'(ift.ACK_READY_TO_MODULE), 8'h1);
        tick();
        ift.ACK_READY = 1'b0;
        chk("col_valid", 8'(ift.ACK_VALID), 8'h0);
        chk("col_err",   8'(ift.TIMEOUT_ERR), 8'h0);

        // New timeout coinciding with ERR_CLR: set wins
        ift.MODULE_SIDE_ACK_VALID = 4'b1000;
        tick();
        chk("sw_id", 8'(ift.MODULE_SOURCE_ID), 8'h3);
        tick();
        tick();
        tick();
        ift.MODULE_SIDE_ACK_VALID = 4'b0000;
        ift.ERR_CLR = 1'b1;
        tick();
        ift.ERR_CLR = 1'b0;
        chk("sw_err", 8'(ift.TIMEOUT_ERR), 8'h1);
        chk("sw_tid", 8'(ift.TIMEOUT_ID), 8'h3);
        chk("sw_valid", 8'(ift.ACK_VALID), 8'h0);

        // Async reset in the middle of a grant to ID 3
        do_reset();
        ifa.MODULE_SIDE_ACK_VALID = 4'b1000;
        tick();
        tick();
        chk("ar_pre_id", 8'(ifa.MODULE_SOURCE_ID), 8'h3);
        chk("ar_pre_valid", 8'(ifa.ACK_VALID), 8'h1);
        #2;
        rst = 1'b1;
        ifa.ACK_READY = 1'b1;
        #1;
        chk("ar_valid", 8'(ifa.ACK_VALID), 8'h0);
        chk("ar_busy",  8'(ifa.BUSY), 8'h0);
        chk("ar_id",    8'(ifa.MODULE_SOURCE_ID), 8'h0);
        chk("ar_strb",  8'(ifa.ACK_READY_TO_MODULE), 8'h0);
        chk("ar_err",   8'(ifa.TIMEOUT_ERR), 8'h0);
        ifa.ACK_READY = 1'b0;
        ifa.MODULE_SIDE_ACK_VALID = 4'b1001;
        tick();
        rst = 1'b0;
        #1;
        tick();
        chk("ar_first_id", 8'(ifa.MODULE_SOURCE_ID), 8'h0);
        chk("ar_first_valid", 8'(ifa.ACK_VALID), 8'h1);
        ifa.ACK_READY = 1'b1;
        ifa.MODULE_SIDE_ACK_VALID = 4'b1000;
        #1;
        chk("ar_first_strb", 8'(ifa.ACK_READY_TO_MODULE), 8'h1);
        tick();
        chk("ar_next_id", 8'(ifa.MODULE_SOURCE_ID), 8'h3);
        chk("ar_next_valid", 8'(ifa.ACK_VALID), 8'h1);
        chk("ar_next_strb", 8'(ifa.ACK_READY_TO_MODULE), 8'h8);
        ifa.MODULE_SIDE_ACK_VALID = 4'b0000;
        tick();
        chk("ar_end_valid", 8'(ifa.ACK_VALID), 8'h0);
        ifa.ACK_READY = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ack_bus_arbiter.md
ACK_BUS_ARBITER -- requirements
Module: ack_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles ACK_VALID is held without ACK_READY before abort; legal range 2..255.
REQ-002 Clock and reset SHALL be one clock, clk, and an asynchronous, active-high reset, rst.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 MODULE_SIDE_ACK_VALID  input  4  per-requester ack request; bit i = source ID i; level, held until served.
REQ-006 ACK_READY_TO_MODULE  output  4  per-requester completion strobe; one-hot or zero.
REQ-007 ACK_VALID  output  1  ack bus valid toward destination.
REQ-008 MODULE_SOURCE_ID  output  2  ID of granted requester; meaningful while ACK_VALID=1.
REQ-009 ACK_READY  input  1  destination accepts ack when high with ACK_VALID.
REQ-010 ERR_CLR  input  1  synchronous clear of TIMEOUT_ERR.
REQ-011 TIMEOUT_ERR  output  1  sticky flag: a grant was aborted by timeout.
REQ-012 TIMEOUT_ID  output  2  ID of most recent timed-out requester.
REQ-013 BUSY  output  1  high while in GRANT state.

Function
REQ-014 FSM SHALL have two states: IDLE (ACK_VALID=0) and GRANT (ACK_VALID=1); ACK_VALID, MODULE_SOURCE_ID, BUSY are registered.
REQ-015 IDLE: if any MODULE_SIDE_ACK_VALID bit set, select winner, load MODULE_SOURCE_ID, go GRANT; ACK_VALID rises the cycle after request is sampled (1-cycle latency).
REQ-016 Arbitration SHALL be round-robin: search starts at LAST+1 mod 4 and wraps; LAST = ID of last grant ended (handshake or timeout); LAST resets to 3, so ID 0 wins first.
REQ-017 GRANT: MODULE_SOURCE_ID and ACK_VALID SHALL stay stable until handshake or timeout.
REQ-018 Handshake = ACK_VALID & ACK_READY in same cycle; ACK_READY_TO_MODULE[MODULE_SOURCE_ID] SHALL be 1 combinationally in that cycle only; all other bits 0; all bits 0 outside handshake.
REQ-019 On handshake, if any request other than current grantee is set, arbiter SHALL re-arbitrate in the same cycle (current grantee masked) and remain in GRANT with new ID next cycle (back-to-back, no bubble); else go IDLE.
REQ-020 Timeout counter (8 bits) SHALL clear on entry to GRANT and increment each GRANT cycle without ACK_READY.
REQ-021 When counter = TIMEOUT_CYCLES-1 and ACK_READY=0: go IDLE, drop ACK_VALID next cycle, set TIMEOUT_ERR, load TIMEOUT_ID with granted ID, update LAST; no ACK_READY_TO_MODULE strobe.
REQ-022 ACK_READY arriving in the timeout cycle SHALL win: treated as handshake, no error.
REQ-023 ACK_READY while ACK_VALID=0 SHALL be ignored.
REQ-024 A requester dropping its request during GRANT SHALL not abort the grant; grant completes by handshake or timeout.
REQ-025 ERR_CLR clears TIMEOUT_ERR next cycle; simultaneous new timeout and ERR_CLR: set wins.

Reset
REQ-026 rst asserted SHALL immediately force: state IDLE, ACK_VALID=0, MODULE_SOURCE_ID=0, BUSY=0, TIMEOUT_ERR=0, TIMEOUT_ID=0, counter=0, LAST=3; ACK_READY_TO_MODULE=0.
REQ-027 Reset mid-GRANT SHALL abandon the grant without strobe or error; first arbitration after release follows REQ-016 from LAST=3.

Verification
REQ-028 Single request: VALID=0001, READY=1 -> ACK_VALID=1, ID=0 one cycle later; ACK_READY_TO_MODULE=0001 one cycle; then IDLE.
REQ-029 Round-robin: VALID=1111 held, READY=1 continuously -> IDs 0,1,2,3,0 on consecutive cycles, ACK_VALID never drops.
REQ-030 Backpressure: VALID=0100, READY low 5 cycles then high -> ID=2 stable 5 cycles, single strobe 0100 at handshake.
REQ-031 Timeout: TIMEOUT_CYCLES=4, VALID=0010, READY=0 -> ACK_VALID high exactly 4 cycles, then TIMEOUT_ERR=1, TIMEOUT_ID=1, no strobe; ERR_CLR pulse -> TIMEOUT_ERR=0.
REQ-032 Timeout/ready collision: READY rises in cycle counter=TIMEOUT_CYCLES-1 -> strobe issued, TIMEOUT_ERR stays 0.
REQ-033 Async reset mid-GRANT: rst between edges with ID=3 granted -> ACK_VALID=0 immediately; after release VALID=1001 -> ID 0 granted first.
